// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding, default widths
// and the fixed attributes of an instruction fetch access.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // A fetch is always a full-word read.
    localparam logic [3:0] FETCH_BE = 4'hF;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [CNT_W-1:0]  r_starve;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;

    logic w_arb_ok;
    logic w_grant_if;
    logic w_grant_d;
    logic w_done_if;
    logic w_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // No grant in a cycle carrying a valid pulse: the completing requester's
    // level is stale, so both requests are judged together one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_done_if    = 1'b0;
        w_done_d     = 1'b0;
        w_arb_ok     = ~r_if_valid & ~r_d_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_ok) begin
                    if (d_req && (!if_req || (r_starve != STARVE_C))) begin
                        w_grant_d    = 1'b1;
                        w_state_next = ST_BUSY_D;
                    end else if (if_req) begin
                        w_grant_if   = 1'b1;
                        w_state_next = ST_BUSY_IF;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (mem_ready) begin
                    w_done_if    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    w_done_d     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant_if) begin
            r_starve <= '0;
        end else if (w_grant_d && if_req) begin
            if (r_starve != STARVE_C) begin
                r_starve <= r_starve + CNT_W'(1);
            end
        end else if ((r_state == ST_IDLE) && !if_req) begin
            r_starve <= '0;
        end
    end

    // Access attributes are latched at grant so the memory port stays stable
    // no matter what the requesters do while the access is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= '0;
        end else if (w_grant_d) begin
            r_addr  <= d_addr;
            r_we    <= d_we;
            r_be    <= d_be;
            r_wdata <= d_wdata;
        end else if (w_grant_if) begin
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_be    <= FETCH_BE;
            r_wdata <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_valid <= w_done_if;
            r_d_valid  <= w_done_d;
            if (w_done_if) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_done_d && !r_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_D);
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;

    assign stall_if  = if_req & ~r_if_valid;
    assign stall_mem = d_req & ~r_d_valid;

endmodule
